// File: rtl/filter_pkg.sv
// Shared widths for the filter and its requantising output stage.
package filter_pkg;
  localparam int FILT_IN_W  = 8;
  localparam int FILT_OUT_W = 17;
  localparam int REQ_OUT_W  = 8;

  // Counter width that stays legal when the modulus is 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full/empty decode cleanly.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A write into a full FIFO still lands when the same edge frees a slot.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    level_d  = level_q + LW'(do_wr) - LW'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
  assign level   = level_q;
endmodule

// File: rtl/filter_requant.sv
// Decimate, round-shift and saturate the filter stream, then buffer it behind valid/ready.
module filter_requant
  import filter_pkg::*;
#(
  parameter int IN_W  = FILT_OUT_W,
  parameter int OUT_W = REQ_OUT_W,
  parameter int SHIFT = 4,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_W-1:0]            in,
  input  logic                       in_en,
  output logic [OUT_W-1:0]           out,
  output logic                       out_en,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       sat,
  output logic                       ovf
);
  localparam int CW      = cnt_w(DECIM);
  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [IN_W:0] RND  = (SHIFT > 0) ? ((IN_W+1)'(1) << RND_POS) : '0;
  localparam logic [IN_W:0] MAXV = {{(IN_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stage_vld_q, stage_vld_d;
  logic [OUT_W-1:0] stage_q, stage_d;
  logic             sat_q, sat_d, ovf_q, ovf_d;
  logic             keep, r_sat, pop;
  logic [IN_W:0]    r;
  logic             fifo_empty, fifo_full;
  logic [OUT_W-1:0] fifo_data;

  always_comb begin
    keep  = in_en && (cnt_q == '0);
    // One extra bit so the rounding add cannot lose its carry at full scale.
    r     = ({1'b0, in} + RND) >> SHIFT;
    r_sat = (r > MAXV);

    cnt_d = cnt_q;
    if (in_en) cnt_d = (cnt_q == CW'(DECIM - 1)) ? '0 : cnt_q + CW'(1);

    stage_vld_d = keep;
    stage_d     = stage_q;
    if (keep) stage_d = r_sat ? '1 : r[OUT_W-1:0];

    // Full implies non-empty, so a pop here always frees the slot.
    pop   = out_rdy && !fifo_empty;
    sat_d = sat_q | (keep & r_sat);
    ovf_d = ovf_q | (stage_vld_q & fifo_full & !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      stage_vld_q <= 1'b0;
      stage_q     <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      stage_vld_q <= stage_vld_d;
      stage_q     <= stage_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (stage_vld_q),
    .wr_data (stage_q),
    .rd_en   (out_rdy),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (level)
  );

  assign out_en = !fifo_empty;
  assign out    = fifo_empty ? '0 : fifo_data;
  assign sat    = sat_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_filter_requant.sv
// Randomised + directed bench for filter_requant with a queue-based reference model.
module tb_filter_requant;
  import filter_pkg::*;
  localparam int IN_W  = FILT_OUT_W;
  localparam int OUT_W = REQ_OUT_W;
  localparam int SHIFT = 4;
  localparam int DECIM = 2;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH+1);
  localparam int OMAX  = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, in_en = 1'b0, out_rdy = 1'b0;
  logic [IN_W-1:0] din = '0;
  logic [OUT_W-1:0] dout;
  logic            out_en, sat, ovf;
  logic [LW-1:0]   level;

  logic            s0_rst = 1'b1, s0_en = 1'b0, s0_rdy = 1'b0;
  logic [IN_W-1:0] s0_in = '0;
  logic [OUT_W-1:0] s0_out;
  logic            s0_out_en, s0_sat, s0_ovf;
  logic [LW-1:0]   s0_level;

  filter_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DECIM), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .in(din), .in_en(in_en), .out(dout), .out_en(out_en),
    .out_rdy(out_rdy), .level(level), .sat(sat), .ovf(ovf));

  filter_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0), .DECIM(1), .DEPTH(DEPTH)) u_s0 (
    .clk(clk), .rst(s0_rst), .in(s0_in), .in_en(s0_en), .out(s0_out), .out_en(s0_out_en),
    .out_rdy(s0_rdy), .level(s0_level), .sat(s0_sat), .ovf(s0_ovf));

  int n_chk = 0, n_err = 0;
  int exp_q[$];
  int m_cnt = 0, m_occ = 0, m_stg_val = 0;
  bit m_stg_vld = 0, m_sat = 0, m_ovf = 0;

  function automatic int ref_val(input int x, input int sh, output bit s);
    int r;
    r = (x + ((sh > 0) ? (1 << (sh - 1)) : 0)) >> sh;
    s = (r > OMAX);
    return s ? OMAX : r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the reference model across the coming edge, drive inputs, then check state after it.
  task automatic cyc(input bit r, input bit en, input int x, input bit rdy);
    bit pop, keep, s;
    rst = r; in_en = en; din = IN_W'(x); out_rdy = rdy;
    if (r) begin
      m_cnt = 0; m_occ = 0; m_stg_vld = 0; m_sat = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      pop = (m_occ > 0) && rdy;
      if (m_stg_vld) begin
        if (m_occ < DEPTH || pop) begin exp_q.push_back(m_stg_val); m_occ++; end
        else m_ovf = 1;
      end
      if (pop) m_occ--;
      keep = en && (m_cnt % DECIM == 0);
      if (en) m_cnt++;
      m_stg_vld = keep;
      if (keep) begin
        m_stg_val = ref_val(x, SHIFT, s);
        if (s) m_sat = 1;
      end
    end
    @(posedge clk); #1;
    chk("level", level, m_occ);
    chk("out_en", out_en, m_occ > 0);
    chk("sat", sat, m_sat);
    chk("ovf", ovf, m_ovf);
    if (m_occ > 0) chk("head", dout, exp_q[0]);
    else chk("out_idle", dout, 0);
  endtask

  // Monitor: every handshake pops one expected sample.
  always @(negedge clk) begin
    int e;
    if (rst === 1'b0 && out_en === 1'b1 && out_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL pop_extra: got %0d expected no output", dout);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", dout, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset; SHIFT=0 instance exercised alongside.
    repeat (3) cyc(1, 0, 0, 0);
    s0_rst = 0; s0_en = 1; s0_in = 255;
    cyc(1, 0, 0, 0);
    chk("s0_sat_255", s0_sat, 0);
    s0_in = 256;
    cyc(1, 0, 0, 0);
    chk("s0_out_en", s0_out_en, 1);
    chk("s0_out_255", s0_out, 255);
    chk("s0_sat_256", s0_sat, 1);
    s0_en = 0;
    cyc(1, 0, 0, 0);
    chk("s0_level", s0_level, 2);
    chk("s0_head", s0_out, 255);

    // Latency: 40 -> 3
    cyc(0, 1, 40, 1);
    cyc(0, 0, 0, 1);
    chk("lat_out", dout, 3);
    repeat (3) cyc(0, 0, 0, 1);

    // Decimation and rounding
    cyc(1, 0, 0, 1);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 16 * i, 1);
    repeat (4) cyc(0, 0, 0, 1);

    // Saturation at max input
    cyc(1, 0, 0, 1);
    cyc(0, 1, 'h1FFFF, 1);
    repeat (5) cyc(0, 0, 0, 1);
    chk("sat_sticky", sat, 1);

    // Overflow and hold
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 8 * i, 0);
    repeat (2) cyc(0, 0, 0, 0);
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", ovf, 1);
    repeat (6) cyc(0, 0, 0, 1);

    // Push into a full FIFO on the same edge as a pop
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, $urandom_range(0, 4095), (m_occ == DEPTH) && m_stg_vld);
    chk("pp_ovf", ovf, 0);
    chk("pp_level", level, DEPTH);
    repeat (6) cyc(0, 0, 0, 1);

    // Mid-operation reset
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 64 + 16 * i, 0);
    chk("mr_level", level, 3);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 100, 1);
    cyc(0, 0, 0, 1);
    chk("mr_kept", dout, 6);
    repeat (3) cyc(0, 0, 0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
          ($urandom_range(0, 3) == 0) ? $urandom_range(4000, 131071) : $urandom_range(0, 4095),
          $urandom_range(0, 1) == 1);
    end
    repeat (8) cyc(0, 0, 0, 1);
    chk("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
